// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers {pc, instr} IMEM responses for decode and discards stale responses after a redirect.
// Optional same-cycle bypass of an empty queue is enabled by defining FQ_BYPASS_EN.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module fetch_queue #(
  parameter int                 DEPTH    = 4,
  parameter int                 PC_W     = `PC_WIDTH,
  parameter int                 INSTR_W  = 32,
  parameter int                 IMEM_LAT = 1,
  parameter logic [INSTR_W-1:0] NOP      = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [PC_W-1:0]        in_pc,
  input  logic [INSTR_W-1:0]     in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [INSTR_W-1:0]     out_instr,
  output logic                   fq_stall,
  output logic [$clog2(DEPTH):0] fq_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [1:0]         drop_cnt;
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic head_valid;
  logic accept;
  logic bypass;
  logic take;
  logic pop_mem;
  logic push_mem;

  assign head_valid = (count != '0);
  assign accept     = in_valid && (drop_cnt == 2'd0) && !flush;

`ifdef FQ_BYPASS_EN
  assign bypass = accept && !head_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry consumed in the same cycle never touches storage.
  assign take     = bypass && out_ready;
  assign pop_mem  = head_valid && out_ready;
  assign push_mem = accept && !take && ((count < CW'(DEPTH)) || pop_mem);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= 2'd0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= 2'(IMEM_LAT);
    end else begin
      if (drop_cnt != 2'd0) drop_cnt <= drop_cnt - 2'd1;
      if (push_mem) wr_ptr <= wr_ptr + 1'b1;
      if (pop_mem)  rd_ptr <= rd_ptr + 1'b1;
      if (push_mem && !pop_mem)      count <= count + 1'b1;
      else if (pop_mem && !push_mem) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_mem) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  always_comb begin
    out_valid = head_valid || bypass;
    out_pc    = '0;
    out_instr = NOP;
    if (head_valid) begin
      out_pc    = pc_mem[rd_ptr];
      out_instr = instr_mem[rd_ptr];
    end else if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end
  end

  assign fq_stall = (count >= CW'(DEPTH - 1));
  assign fq_count = count;

endmodule
